// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the md op encoding, the iteration counter width and the control FSM state type.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int unsigned MD_CNT_W = 4;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_divider.sv
// 32-bit combinational divider with signed/unsigned mode.
// Ports:
//   is_signed  treat operands as two's complement
//   dividend   numerator
//   divisor    denominator (zero yields zero outputs; the caller suppresses the write)
//   quotient   truncated toward zero
//   remainder  carries the sign of the dividend
module md_divider (
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] uq;
   logic [31:0] ur;

   always_comb begin
      neg_a = is_signed & dividend[31];
      neg_b = is_signed & divisor[31];
      // 0x80000000 negates to itself, which is the correct magnitude as an unsigned value
      abs_a = neg_a ? (~dividend + 32'd1) : dividend;
      abs_b = neg_b ? (~divisor + 32'd1) : divisor;
      if (abs_b == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = abs_a / abs_b;
         ur = abs_a % abs_b;
      end
      quotient  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      remainder = neg_a ? (~ur + 32'd1) : ur;
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// An md op accepted in IDLE keeps busy high for exactly MULT_CYCLES or DIV_CYCLES cycles;
// the result lands on the edge that drops busy. mthi/mtlo write in a single cycle.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   start, op   issue strobe and op code (md_op_e)
//   rs_val      operand A / mthi-mtlo source
//   rt_val      operand B
//   cancel      flush: drop any in-flight op and any same-cycle start
//   busy        op in flight
//   hi, lo      HI/LO registers
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYCLES);

   md_state_e             state_q;
   logic [MD_CNT_W-1:0]   cnt_q;
   logic [2:0]            op_q;
   logic [31:0]           a_q;
   logic [31:0]           b_q;
   logic [31:0]           hi_q;
   logic [31:0]           lo_q;
   logic                  busy_q;

   logic                  is_signed;
   logic [63:0]           ma;
   logic [63:0]           mb;
   logic [63:0]           prod;
   logic [31:0]           quo;
   logic [31:0]           rem;
   logic [31:0]           res_hi;
   logic [31:0]           res_lo;
   logic                  res_wr;

   assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);

   // The low 64 bits of a 64x64 product are right for both signednesses once the
   // operands are extended accordingly.
   always_comb begin
      ma   = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      mb   = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod = ma * mb;
   end

   md_divider u_div (
      .is_signed (is_signed),
      .dividend  (a_q),
      .divisor   (b_q),
      .quotient  (quo),
      .remainder (rem)
   );

   always_comb begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
      if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
         res_hi = rem;
         res_lo = quo;
         // Divide by zero runs the full latency but leaves HI/LO untouched
         res_wr = (b_q != 32'd0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
      end else if (cancel) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  case (op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        op_q    <= op;
                        a_q     <= rs_val;
                        b_q     <= rt_val;
                        cnt_q   <= (op == MD_DIV || op == MD_DIVU) ? DivLoad : MultLoad;
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                     end
                     MD_MTHI: hi_q <= rs_val;
                     MD_MTLO: lo_q <= rs_val;
                     default: ;
                  endcase
               end
            end
            StRun: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == MD_CNT_W'(1)) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  if (res_wr) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, mthi/mtlo, divide by zero, cancel, reset.
module tb_md_unit;
   import md_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        cancel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp;
   int n_err;
   int cycles;

   md_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Count cycles busy stays high after the accepting edge (bounded).
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      issue(o, a, b);
      wait_idle(n);
      check({tag, " latency"}, n, lat);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      reset  = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      rs_val = 32'd0;
      rt_val = 32'd0;
      cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE,
             32'h0000_0001);
      run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 7/2", MD_DIVU, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001,
             32'h0000_0003);
      run_op("div 7/-2", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000,
             32'h8000_0000);
      run_op("divu big", MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF);

      // mthi then mtlo on consecutive cycles
      @(negedge clk);
      start  = 1'b1;
      op     = MD_MTHI;
      rs_val = 32'h1234_5678;
      @(posedge clk);
      #1;
      check("mthi hi", hi, 32'h1234_5678);
      check("mthi lo kept", lo, 32'h0FFF_FFFF);
      check("mthi busy", {31'd0, busy}, 32'd0);
      op     = MD_MTLO;
      rs_val = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      start  = 1'b0;
      check("mtlo lo", lo, 32'h9ABC_DEF0);
      check("mtlo hi kept", hi, 32'h1234_5678);
      check("mtlo busy", {31'd0, busy}, 32'd0);

      // Divide by zero leaves preloaded HI/LO alone
      issue(MD_MTHI, 32'hAAAA_0000, 32'd0);
      issue(MD_MTLO, 32'h0000_BBBB, 32'd0);
      run_op("div by 0", MD_DIV, 32'h0000_0005, 32'h0000_0000, 10, 32'hAAAA_0000, 32'h0000_BBBB);
      run_op("divu by 0", MD_DIVU, 32'h0000_0005, 32'h0000_0000, 10, 32'hAAAA_0000,
             32'h0000_BBBB);

      // Start while running is ignored
      issue(MD_MULTU, 32'h0000_0002, 32'h0000_0003);
      @(negedge clk);
      start  = 1'b1;
      op     = MD_MTHI;
      rs_val = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      start  = 1'b0;
      check("start in run hi", hi, 32'hAAAA_0000);
      wait_idle(cycles);
      check("start in run latency", cycles + 1, 5);
      check("start in run res hi", hi, 32'h0000_0000);
      check("start in run res lo", lo, 32'h0000_0006);

      // Undefined op code does nothing
      issue(3'd6, 32'h5555_5555, 32'h0000_0001);
      check("undef busy", {31'd0, busy}, 32'd0);
      check("undef hi", hi, 32'h0000_0000);
      check("undef lo", lo, 32'h0000_0006);

      // Cancel on the 3rd busy cycle
      issue(MD_MULT, 32'h0000_0010, 32'h0000_0010);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("cancel pre busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cancel busy", {31'd0, busy}, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("cancel hi", hi, 32'h0000_0000);
      check("cancel lo", lo, 32'h0000_0006);
      check("cancel stays idle", {31'd0, busy}, 32'd0);

      // Cancel beats a same-cycle start
      @(negedge clk);
      cancel = 1'b1;
      start  = 1'b1;
      op     = MD_MTHI;
      rs_val = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      start  = 1'b0;
      check("cancel+start hi", hi, 32'h0000_0000);
      check("cancel+start busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a divide
      issue(MD_MTHI, 32'h0BAD_0BAD, 32'd0);
      issue(MD_DIV, 32'h0000_0064, 32'h0000_0007);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre reset busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("async reset busy", {31'd0, busy}, 32'd0);
      check("async reset hi", hi, 32'd0);
      check("async reset lo", lo, 32'd0);
      repeat (12) @(posedge clk);
      #1;
      check("held reset lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("div after reset", MD_DIV, 32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002,
             32'h0000_000E);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the pipelined MIPS core, directly downstream of the execute stage.
- Consumes the EX-stage operand pair (rs/rt values) on mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- Drives busy so the hazard logic stalls later HI/LO users (mfhi, mflo, md ops) until the result has landed.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  EX stage issues an md op this cycle.
- op  input  3  operation code (see Decomposition).
- rs_val  input  32  operand A / mthi-mtlo source.
- rt_val  input  32  operand B.
- cancel  input  1  abort any in-flight op (pipeline flush).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, state IDLE.
- States: IDLE, RUN.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch op and operands at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the cycle after start.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - Write the result to hi/lo.
  - busy=0 and state IDLE from the next cycle.
  - Total: busy is high for exactly N cycles, and the result is visible the cycle busy falls.
- mthi/mtlo: with start=1 in IDLE, hi (or lo) <= rs_val at that edge. Single cycle, busy stays 0.
- start while RUN: ignored (hazard unit guarantees this never happens; the bench checks it is a no-op).
- Results:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Any 32-bit product/quotient datapath may be used: combinational on the latched operands or iterative, as long as the latency is exact.
- Divide by zero (rt_val==0, DIV or DIVU): the full busy latency still elapses; hi/lo are left unchanged.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- cancel=1:
  - State returns to IDLE and busy=0 next cycle; hi/lo unchanged; the in-flight result is discarded.
  - cancel has priority over start in the same cycle, so the start is dropped.
- Result completion and a new start on the same edge cannot happen, because start is only accepted in IDLE. A start in the cycle right after busy falls is accepted normally.
- Undefined op codes with start=1: no effect.
- Asynchronous reset mid-operation: immediate return to reset values; no partial write.

Decomposition:
- Shared package md_pkg holds:
  - Op encoding: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - Counter width constant MD_CNT_W=4.
- Optional sub-module md_divider (32-bit signed/unsigned quotient/remainder with sign fix-up), used so the arithmetic can be unit-tested apart from the control FSM. The multiplier stays inline.

Test Plan:
- Reset release, then MULT rs=0xFFFFFFFE(-2), rt=0x00000003 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> busy never asserts; hi/lo updated on each respective edge.
- DIV 5/0 with hi=0xAAAA0000, lo=0x0000BBBB preloaded -> busy 10 cycles; hi/lo unchanged.
- MULT start, cancel on 3rd busy cycle -> busy=0 next cycle; hi/lo keep prior values. Repeat with reset pulled low mid-DIV -> hi=lo=0, busy=0 immediately.
